// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: HI/LO register pair plus a multi-cycle MULT/MULTU/DIV/DIVU
// sequencer. Multiply is radix-2 shift-add, divide is restoring (one bit per
// cycle). Signed operations run on magnitudes and fix the signs at the end.
// Optional feature macro: MD_FAST_MULT_EN (single-cycle combinational multiply).
`timescale 1ns/1ps
module hilo_muldiv_ctrl #(
  parameter int DATA_W = 32,
  parameter int ITER   = 32
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic [1:0]        dbg_state
);

  // Handshake: the decoder holds start (with op/rs_val/rt_val) for the whole
  // time the instruction sits at the PC. The operation is accepted on the
  // first edge of start in IDLE; done pulses for exactly one cycle in DONE,
  // where the CPU retires the instruction. start seen in DONE is the same
  // instruction and is ignored; start still high in the following IDLE cycle
  // is a new (back-to-back) instruction.

  localparam int                CNT_W    = $clog2(ITER);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [1:0]            r_op;
  logic                  r_neg_lo;    // product / quotient is negative
  logic                  r_neg_hi;    // remainder is negative
  logic [DATA_W-1:0]     r_opb;       // multiplicand or divisor magnitude
  logic [2*DATA_W-1:0]   r_acc;       // {upper work half, multiplier/quotient bits}
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_W-1:0]     r_hi;
  logic [DATA_W-1:0]     r_lo;
  logic                  r_div_zero;

  logic                  w_signed_op;
  logic [DATA_W-1:0]     w_rs_mag;
  logic [DATA_W-1:0]     w_rt_mag;
  logic                  w_fast;
  logic [DATA_W:0]       w_mul_sum;
  logic [2*DATA_W-1:0]   w_mul_nxt;
  logic [DATA_W:0]       w_rem_sh;
  logic                  w_div_ge;
  logic [DATA_W-1:0]     w_rem_nxt;
  logic [2*DATA_W-1:0]   w_div_nxt;
  logic [2*DATA_W-1:0]   w_acc_nxt;
  logic [2*DATA_W-1:0]   w_prod;
  logic [DATA_W-1:0]     w_quot;
  logic [DATA_W-1:0]     w_rem;
  logic [DATA_W-1:0]     w_res_hi;
  logic [DATA_W-1:0]     w_res_lo;

  // Operand preparation: MULT and DIV (op[0]==0) are the signed flavours
  assign w_signed_op = ~op[0];
  assign w_rs_mag    = (w_signed_op & rs_val[DATA_W-1]) ? -rs_val : rs_val;
  assign w_rt_mag    = (w_signed_op & rt_val[DATA_W-1]) ? -rt_val : rt_val;

`ifdef MD_FAST_MULT_EN
  logic [2*DATA_W-1:0] w_fast_a;
  logic [2*DATA_W-1:0] w_fast_b;
  logic [2*DATA_W-1:0] w_fast_prod;
  // Sign-extend to full width; the low 2*DATA_W bits of the product are then
  // correct for both signed and unsigned operands.
  assign w_fast_a    = {{DATA_W{w_signed_op & rs_val[DATA_W-1]}}, rs_val};
  assign w_fast_b    = {{DATA_W{w_signed_op & rt_val[DATA_W-1]}}, rt_val};
  assign w_fast_prod = w_fast_a * w_fast_b;
  assign w_fast      = start & ~op[1];
`else
  assign w_fast      = 1'b0;
`endif

  // Shift-add step: add multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right.
  assign w_mul_sum = {1'b0, r_acc[2*DATA_W-1:DATA_W]}
                   + {1'b0, (r_acc[0] ? r_opb : {DATA_W{1'b0}})};
  assign w_mul_nxt = {w_mul_sum, r_acc[DATA_W-1:1]};

  // Restoring divide step: shift the next dividend bit into the remainder,
  // subtract the divisor when it fits and record the quotient bit.
  assign w_rem_sh  = {r_acc[2*DATA_W-1:DATA_W], r_acc[DATA_W-1]};
  assign w_div_ge  = (w_rem_sh >= {1'b0, r_opb});
  assign w_rem_nxt = w_div_ge ? (w_rem_sh[DATA_W-1:0] - r_opb) : w_rem_sh[DATA_W-1:0];
  assign w_div_nxt = {w_rem_nxt, r_acc[DATA_W-2:0], w_div_ge};

  assign w_acc_nxt = r_op[1] ? w_div_nxt : w_mul_nxt;

  // Sign correction on the final iteration's result
  assign w_prod   = r_neg_lo ? -w_acc_nxt : w_acc_nxt;
  assign w_quot   = r_neg_lo ? -w_acc_nxt[DATA_W-1:0] : w_acc_nxt[DATA_W-1:0];
  assign w_rem    = r_neg_hi ? -w_acc_nxt[2*DATA_W-1:DATA_W] : w_acc_nxt[2*DATA_W-1:DATA_W];
  assign w_res_hi = r_op[1] ? w_rem  : w_prod[2*DATA_W-1:DATA_W];
  assign w_res_lo = r_op[1] ? w_quot : w_prod[DATA_W-1:0];

  // Sequencer FSM, HI/LO register pair and MTHI/MTLO writes
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_op       <= 2'b00;
      r_neg_lo   <= 1'b0;
      r_neg_hi   <= 1'b0;
      r_opb      <= {DATA_W{1'b0}};
      r_acc      <= {(2*DATA_W){1'b0}};
      r_cnt      <= {CNT_W{1'b0}};
      r_hi       <= {DATA_W{1'b0}};
      r_lo       <= {DATA_W{1'b0}};
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_div_zero <= 1'b0;
          if (start) begin
            r_op     <= op;
            r_neg_lo <= w_signed_op & (rs_val[DATA_W-1] ^ rt_val[DATA_W-1]);
            r_neg_hi <= w_signed_op & rs_val[DATA_W-1];
            r_opb    <= w_rt_mag;
            r_acc    <= {{DATA_W{1'b0}}, w_rs_mag};
            r_cnt    <= CNT_LOAD;
            if (op[1] && (rt_val == {DATA_W{1'b0}})) begin
              r_div_zero <= 1'b1;
              r_state    <= S_DONE;
            end
`ifdef MD_FAST_MULT_EN
            else if (!op[1]) begin
              r_hi    <= w_fast_prod[2*DATA_W-1:DATA_W];
              r_lo    <= w_fast_prod[DATA_W-1:0];
              r_state <= S_DONE;
            end
`endif
            else begin
              r_state <= S_CALC;
            end
          end else begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
          end
        end
        S_CALC: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == {CNT_W{1'b0}}) begin
            r_hi    <= w_res_hi;
            r_lo    <= w_res_lo;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_div_zero <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // The start cycle of a slow operation is already stalled; reset drops it at once
  assign stall     = reset & (((r_state == S_IDLE) & start & ~w_fast) | (r_state == S_CALC));
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign div_zero  = r_div_zero;
  assign hi_out    = r_hi;
  assign lo_out    = r_lo;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb_hilo_muldiv_ctrl: directed and randomized bench for hilo_muldiv_ctrl.
// Expected HI/LO come from plain 64-bit arithmetic in model_issue().
`timescale 1ns/1ps
module tb_hilo_muldiv_ctrl;

  localparam int MAX_WAIT = 100;

  logic        clk_in;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        stall;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard: {div_zero, HI, LO} expected at each done
  logic [64:0] exp_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  hilo_muldiv_ctrl dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .wdata     (wdata),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int exp_cycles(input logic [1:0] f_op, input logic [31:0] b);
    if (f_op[1] && b == 32'd0) return 1;
`ifdef MD_FAST_MULT_EN
    if (!f_op[1]) return 1;
`endif
    return 33;
  endfunction

  function automatic int exp_stalls(input logic [1:0] f_op, input logic [31:0] b);
    if (f_op[1] && b == 32'd0) return 1;
`ifdef MD_FAST_MULT_EN
    if (!f_op[1]) return 0;
`endif
    return 33;
  endfunction

  task automatic model_issue(input logic [1:0] f_op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sq, sr;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (f_op[1] && b == 32'd0) begin
      exp_q.push_back({1'b1, m_hi, m_lo});
    end else begin
      case (f_op)
        2'b00: begin up = sa * sb; m_hi = up[63:32]; m_lo = up[31:0]; end
        2'b01: begin up = {32'd0, a} * {32'd0, b}; m_hi = up[63:32]; m_lo = up[31:0]; end
        2'b10: begin sq = sa / sb; sr = sa % sb; m_lo = sq[31:0]; m_hi = sr[31:0]; end
        default: begin m_lo = a / b; m_hi = a % b; end
      endcase
      exp_q.push_back({1'b0, m_hi, m_lo});
    end
  endtask

  // ---------------- driver tasks ----------------
  // Issues one instruction (start held) and returns at #1 into its done cycle.
  task automatic run_op(input logic [1:0] f_op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output int stalls, output logic [64:0] got,
                        output logic done_stall);
    start  = 1'b1;
    op     = f_op;
    rs_val = a;
    rt_val = b;
    #1;
    if (done === 1'b1) tick();
    model_issue(f_op, a, b);
    cyc    = 0;
    stalls = 0;
    while (done !== 1'b1 && cyc < MAX_WAIT) begin
      if (stall === 1'b1) stalls++;
      cyc++;
      tick();
    end
    got        = {div_zero, hi_out, lo_out};
    done_stall = stall;
  endtask

  task automatic finish_op();
    start = 1'b0;
    tick();
  endtask

  task automatic do_mt(input logic h, input logic l, input logic [31:0] d);
    hi_we = h;
    lo_we = l;
    wdata = d;
    tick();
    hi_we = 1'b0;
    lo_we = 1'b0;
    if (h) m_hi = d;
    if (l) m_lo = d;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    m_hi = '0; m_lo = '0;
    repeat (3) tick();
    n_checks++;
    if ({stall, busy, done, div_zero} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_flags: got stall/busy/done/dz=%b required 0000", {stall, busy, done, div_zero});
    end
    n_checks++;
    if ({hi_out, lo_out} !== 64'd0) begin
      n_errors++;
      $display("FAIL reset_hilo: got %h_%h required 0", hi_out, lo_out);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_mul();
    logic [1:0]  t_op[3] = '{2'b01, 2'b00, 2'b01};
    logic [31:0] t_a[3]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd3};
    logic [31:0] t_b[3]  = '{32'hFFFF_FFFF, 32'd7, 32'd4};
    logic [63:0] t_r[3]  = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFEB, 64'd12};
    int cyc, stalls; logic [64:0] got, exp; logic ds;
    for (int i = 0; i < 3; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], cyc, stalls, got, ds);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL mul%0d_model: got %h required %h", i, got, exp); end
      n_checks++;
      if (got[63:0] !== t_r[i]) begin n_errors++; $display("FAIL mul%0d_const: got %h required %h", i, got[63:0], t_r[i]); end
      n_checks++;
      if (cyc != exp_cycles(t_op[i], t_b[i]) || stalls != exp_stalls(t_op[i], t_b[i]) || ds !== 1'b0) begin
        n_errors++;
        $display("FAIL mul%0d_timing: got cycles=%0d stalls=%0d done_stall=%b required %0d/%0d/0",
                 i, cyc, stalls, ds, exp_cycles(t_op[i], t_b[i]), exp_stalls(t_op[i], t_b[i]));
      end
      finish_op();
      n_checks++;
      if ({busy, done, div_zero, stall} !== 4'b0000) begin
        n_errors++; $display("FAIL mul%0d_idle: got busy/done/dz/stall=%b required 0000", i, {busy, done, div_zero, stall});
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc, stalls; logic [64:0] got, exp; logic ds;
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, cyc, stalls, got, ds);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL b2b_first: got %h required %h", got, exp); end
    run_op(2'b00, 32'd2, 32'd3, cyc, stalls, got, ds);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== {1'b0, 32'd0, 32'd6} || got !== exp) begin
      n_errors++; $display("FAIL b2b_second: got %h required %h", got, exp);
    end
    n_checks++;
    if (cyc != exp_cycles(2'b00, 32'd3) || stalls != exp_stalls(2'b00, 32'd3)) begin
      n_errors++; $display("FAIL b2b_timing: got cycles=%0d stalls=%0d required %0d/%0d",
                           cyc, stalls, exp_cycles(2'b00, 32'd3), exp_stalls(2'b00, 32'd3));
    end
    finish_op();
    n_checks++;
    if ({busy, done} !== 2'b00 || exp_q.size() != 0) begin
      n_errors++; $display("FAIL b2b_idle: got busy/done=%b pending=%0d required 00/0", {busy, done}, exp_q.size());
    end
  endtask

  task automatic test_div();
    logic [1:0]  t_op[3] = '{2'b10, 2'b11, 2'b10};
    logic [31:0] t_a[3]  = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
    logic [31:0] t_b[3]  = '{32'd2, 32'd2, 32'hFFFF_FFFF};
    logic [64:0] t_r[3]  = '{{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD}, {1'b0, 32'd1, 32'd3},
                             {1'b0, 32'd0, 32'h8000_0000}};
    int cyc, stalls; logic [64:0] got, exp; logic ds;
    for (int i = 0; i < 3; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], cyc, stalls, got, ds);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp || got !== t_r[i]) begin
        n_errors++; $display("FAIL div%0d_result: got %h required %h", i, got, t_r[i]);
      end
      n_checks++;
      if (cyc != 33 || stalls != 33 || ds !== 1'b0) begin
        n_errors++; $display("FAIL div%0d_timing: got cycles=%0d stalls=%0d done_stall=%b required 33/33/0", i, cyc, stalls, ds);
      end
      finish_op();
    end
  endtask

  task automatic test_div_zero();
    int cyc, stalls; logic [64:0] got, exp; logic ds;
    do_mt(1'b1, 1'b0, 32'h11);
    do_mt(1'b0, 1'b1, 32'h22);
    n_checks++;
    if ({hi_out, lo_out} !== {32'h11, 32'h22}) begin
      n_errors++; $display("FAIL mthi_mtlo: got %h_%h required 00000011_00000022", hi_out, lo_out);
    end
    run_op(2'b10, 32'd5, 32'd0, cyc, stalls, got, ds);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp || got !== {1'b1, 32'h11, 32'h22}) begin
      n_errors++; $display("FAIL divzero_result: got %h required %h", got, {1'b1, 32'h11, 32'h22});
    end
    n_checks++;
    if (cyc != 1 || stalls != 1) begin
      n_errors++; $display("FAIL divzero_timing: got cycles=%0d stalls=%0d required 1/1", cyc, stalls);
    end
    finish_op();
    n_checks++;
    if ({div_zero, done, busy} !== 3'b000) begin
      n_errors++; $display("FAIL divzero_clear: got dz/done/busy=%b required 000", {div_zero, done, busy});
    end
  endtask

  task automatic test_reset_mid();
    int cyc, stalls; logic [64:0] got, exp; logic ds;
    do_mt(1'b1, 1'b1, 32'h55);
    start = 1'b1; op = 2'b01; rs_val = 32'd9; rt_val = 32'd9;
    #1;
    tick();
    repeat (9) tick();
`ifndef MD_FAST_MULT_EN
    n_checks++;
    if ({stall, busy, hi_out, lo_out} !== {2'b11, 32'h55, 32'h55}) begin
      n_errors++; $display("FAIL calc_visible: got stall/busy=%b hi=%h lo=%h required 11/55/55", {stall, busy}, hi_out, lo_out);
    end
`endif
    reset = 1'b0;
    #1;
    n_checks++;
    if ({stall, busy, done, hi_out, lo_out} !== 67'd0) begin
      n_errors++; $display("FAIL reset_mid: got stall/busy/done=%b hi=%h lo=%h required 0", {stall, busy, done}, hi_out, lo_out);
    end
    start = 1'b0;
    tick();
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    tick();
    n_checks++;
    if ({busy, hi_out, lo_out} !== 65'd0) begin
      n_errors++; $display("FAIL reset_release: got busy=%b hi=%h lo=%h required 0", busy, hi_out, lo_out);
    end
    run_op(2'b01, 32'd4, 32'd5, cyc, stalls, got, ds);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp || got[31:0] !== 32'd20) begin
      n_errors++; $display("FAIL after_reset_mul: got %h required %h", got, exp);
    end
    finish_op();
  endtask

  task automatic test_write_ignore();
    int cyc, stalls; logic [64:0] got, exp; logic ds;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hAB;
    run_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, cyc, stalls, got, ds);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL we_during_calc: got %h required %h", got, exp); end
    run_op(2'b11, 32'd5, 32'd0, cyc, stalls, got, ds);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL we_with_start: got %h required %h", got, exp); end
    finish_op();
    hi_we = 1'b0; lo_we = 1'b0;
    n_checks++;
    if ({hi_out, lo_out} !== {m_hi, m_lo}) begin
      n_errors++; $display("FAIL we_in_done: got %h_%h required %h_%h", hi_out, lo_out, m_hi, m_lo);
    end
  endtask

  task automatic test_random();
    int cyc, stalls; logic [64:0] got, exp; logic ds;
    logic [1:0] r_op; logic [31:0] a, b; int cls; bit b2b;
    b2b = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!b2b && $urandom_range(0, 3) == 0) begin
        do_mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        n_checks++;
        if ({hi_out, lo_out} !== {m_hi, m_lo}) begin
          n_errors++; $display("FAIL rnd%0d_mt: got %h_%h required %h_%h", i, hi_out, lo_out, m_hi, m_lo);
        end
      end
      r_op = 2'($urandom_range(0, 3));
      a    = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      cls  = $urandom_range(0, 9);
      b    = (cls == 0) ? 32'd0 : (cls == 1) ? 32'($urandom_range(1, 15)) :
             (cls == 2) ? 32'hFFFF_FFFF : $urandom;
      run_op(r_op, a, b, cyc, stalls, got, ds);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_errors++; $display("FAIL rnd%0d_result: op=%0d a=%h b=%h got %h required %h", i, r_op, a, b, got, exp);
      end
      n_checks++;
      if (cyc != exp_cycles(r_op, b) || stalls != exp_stalls(r_op, b) || ds !== 1'b0) begin
        n_errors++; $display("FAIL rnd%0d_timing: got cycles=%0d stalls=%0d required %0d/%0d",
                             i, cyc, stalls, exp_cycles(r_op, b), exp_stalls(r_op, b));
      end
      b2b = ($urandom_range(0, 3) == 0);
      if (!b2b) begin
        finish_op();
        n_checks++;
        if ({busy, done, div_zero, stall} !== 4'b0000) begin
          n_errors++; $display("FAIL rnd%0d_idle: got busy/done/dz/stall=%b required 0000", i, {busy, done, div_zero, stall});
        end
      end
    end
    if (b2b) finish_op();
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_mul();
    test_back_to_back();
    test_div();
    test_div_zero();
    test_reset_mid();
    test_write_ignore();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
